// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift on device clock, ACK check.
// Define PS2_TX_RESEND_EN to retransmit a NACKed or timed-out byte up to two more times.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [FILTER_LEN-1:0] cfilt_q, cfilt_d, dfilt_q, dfilt_d;
  logic                  ps2cf_q, ps2cf_d, ps2df_q, ps2df_d, ps2cf_prev_q;
  logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic                  dbit_q, dbit_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  fall, accept, timeout, fail;
`ifdef PS2_TX_RESEND_EN
  logic [7:0]            data_q, data_d;
  logic [1:0]            retry_q, retry_d;
`endif

  // Glitch filter: the filtered level only flips once the whole window agrees.
  always_comb begin
    cfilt_d = {cfilt_q[FILTER_LEN-2:0], PS2C};
    dfilt_d = {dfilt_q[FILTER_LEN-2:0], PS2D};
    ps2cf_d = (&cfilt_q) ? 1'b1 : ((~|cfilt_q) ? 1'b0 : ps2cf_q);
    ps2df_d = (&dfilt_q) ? 1'b1 : ((~|dfilt_q) ? 1'b0 : ps2df_q);
  end

  assign fall    = ps2cf_prev_q & ~ps2cf_q;
  assign accept  = tx_valid & tx_ready;
  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cfilt_q      <= '1;
      dfilt_q      <= '1;
      ps2cf_q      <= 1'b1;
      ps2df_q      <= 1'b1;
      ps2cf_prev_q <= 1'b1;
      inh_cnt_q    <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cfilt_q      <= cfilt_d;
      dfilt_q      <= dfilt_d;
      ps2cf_q      <= ps2cf_d;
      ps2df_q      <= ps2df_d;
      ps2cf_prev_q <= ps2cf_q;
      inh_cnt_q    <= inh_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef PS2_TX_RESEND_EN
      retry_q      <= retry_d;
`endif
    end
    shift_q <= shift_d;
    dbit_q  <= dbit_d;
`ifdef PS2_TX_RESEND_EN
    data_q  <= data_d;
`endif
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dbit_d    = dbit_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RESEND_EN
    data_d    = data_q;
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
          data_d    = tx_data;
          retry_d   = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
        else inh_cnt_d = inh_cnt_q + 1'b1;
      end
      S_REQ: begin
        to_cnt_d = '0;
        dbit_d   = 1'b0;
        state_d  = S_WAIT_CLK;
      end
      S_WAIT_CLK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout) begin
          fail = 1'b1;
        end else if (fall) begin
          dbit_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout) fail = 1'b1;
        else if (fall) begin
          if (!ps2df_q) state_d = S_WAIT_IDLE;
          else fail = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timeout) fail = 1'b1;
        else if (ps2cf_q && ps2df_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RESEND_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 1'b1;
        shift_d   = {1'b1, ~^data_q, data_q};
        bit_cnt_d = '0;
        inh_cnt_d = '0;
        state_d   = S_INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = S_IDLE;
`endif
    end
  end

  always_comb begin
    ps2c_oe = 1'b0;
    ps2d_oe = 1'b0;
    case (state_q)
      S_INHIBIT:  ps2c_oe = 1'b1;
      S_REQ: begin
        ps2c_oe = 1'b1;
        ps2d_oe = 1'b1;
      end
      S_WAIT_CLK: ps2d_oe = ~dbit_q;
      default: begin
        ps2c_oe = 1'b0;
        ps2d_oe = 1'b0;
      end
    endcase
    tx_ready  = (state_q == S_IDLE) & ps2cf_q & ps2df_q;
    tx_active = (state_q != S_IDLE);
    tx_done   = done_q;
    tx_err    = err_q;
  end

endmodule
